pcpi_mem_arbiter: RTL and testbench

//   Shares the single data-memory port between two requesters: M0 = PicoRV32 core native

---
 rtl/pcpi_mem_pkg.sv | 15 +
 rtl/pcpi_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_pcpi_mem_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pcpi_mem_pkg.sv
// Shared types and constants for the PicoRV32 / PCPI data-memory arbiter.
package pcpi_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam logic [31:0] ABORT_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/pcpi_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core (M0) and the coprocessor LSU (M1).
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module pcpi_mem_arbiter
  import pcpi_mem_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ready,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          grant_o,
  output logic                timeout_o
);

  arb_state_t  state, state_nxt;
  logic        last_grant, last_grant_nxt;
  logic        sel;
  logic        done;
  logic [DATA_W-1:0] rdata_mux;

  // Granted master: M1 only in GNT1, otherwise M0 (don't-care while idle).
  assign sel = (state == GNT1);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

  logic [CNT_W-1:0] cnt;
  logic             expired;

  // Cycles spent in the current grant; every grant is entered from IDLE, so clearing there suffices.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^(32'(TIMEOUT_CYCLES));
`endif

  // State and round-robin history.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= M1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Next state, request mux and completion handling.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    s_valid        = 1'b0;
    s_addr         = '0;
    s_wdata        = '0;
    s_wstrb        = '0;
    grant_o        = 2'b00;
    timeout_o      = 1'b0;
    done           = 1'b0;
    rdata_mux      = '0;

    case (state)
      IDLE: begin
        if (m0_valid && (!m1_valid || last_grant == M1)) begin
          state_nxt = GNT0;
        end else if (m1_valid) begin
          state_nxt = GNT1;
        end
      end

      GNT0, GNT1: begin
        grant_o = sel ? 2'b10 : 2'b01;
        s_valid = sel ? m1_valid : m0_valid;
        s_addr  = sel ? m1_addr  : m0_addr;
        s_wdata = sel ? m1_wdata : m0_wdata;
        s_wstrb = sel ? m1_wstrb : m0_wstrb;

        if (!s_valid) begin
          // Requester withdrew mid-grant: release without completing or rotating priority.
          state_nxt = IDLE;
        end else if (s_ready) begin
          done      = 1'b1;
          rdata_mux = s_rdata;
`ifdef ARB_TIMEOUT_EN
        end else if (expired) begin
          done      = 1'b1;
          rdata_mux = DATA_W'(ABORT_RDATA);
          s_valid   = 1'b0;
          timeout_o = 1'b1;
`endif
        end

        if (done) begin
          last_grant_nxt = sel;
          state_nxt      = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign m0_ready = done && !sel;
  assign m1_ready = done && sel;
  assign m0_rdata = m0_ready ? rdata_mux : '0;
  assign m1_rdata = m1_ready ? rdata_mux : '0;

endmodule

// File: tb/tb_pcpi_mem_arbiter.sv
// Directed self-checking bench for pcpi_mem_arbiter (both with and without ARB_TIMEOUT_EN).
module tb_pcpi_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic [1:0]  grant_o;
  logic        timeout_o;

  int total = 0;
  int bad   = 0;

  pcpi_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven 1ns after the edge, checks 2ns after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    resetn   = 1'b0;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready  = 1'b0; s_rdata = '0;
    #2;
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_grant",   32'(grant_o), 32'd0);
    chk("rst_m0_ready", 32'(m0_ready), 32'd0);
    tick(); tick();
    resetn = 1'b1;

    // 1: M0 read of 0x100, memory answers on the 3rd grant cycle
    tick();
    m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'b0000; s_ready = 1'b1;
    settle();
    chk("t1_idle_sready_ignored", 32'(m0_ready), 32'd0);
    chk("t1_idle_grant", 32'(grant_o), 32'd0);
    tick(); s_ready = 1'b0; settle();
    chk("t1_s_valid", 32'(s_valid), 32'd1);
    chk("t1_s_addr",  s_addr, 32'h100);
    chk("t1_grant",   32'(grant_o), 32'd1);
    chk("t1_no_ready_early", 32'(m0_ready), 32'd0);
    tick(); settle();
    chk("t1_wait_s_valid", 32'(s_valid), 32'd1);
    tick(); s_ready = 1'b1; s_rdata = 32'h1234_5678; settle();
    chk("t1_m0_ready", 32'(m0_ready), 32'd1);
    chk("t1_m0_rdata", m0_rdata, 32'h1234_5678);
    chk("t1_m1_ready", 32'(m1_ready), 32'd0);
    chk("t1_m1_rdata", m1_rdata, 32'd0);
    tick(); m0_valid = 1'b0; s_ready = 1'b0; settle();
    chk("t1_pulse_end", 32'(m0_ready), 32'd0);
    chk("t1_rdata_zero", m0_rdata, 32'd0);
    chk("t1_back_idle", 32'(grant_o), 32'd0);

    // 2: ties after reset alternate, with an idle cycle between grants
    resetn = 1'b0; tick(); resetn = 1'b1;
    tick();
    m0_valid = 1'b1; m0_addr = 32'h10; m1_valid = 1'b1; m1_addr = 32'h20;
    tick(); s_ready = 1'b1; s_rdata = 32'hA0; settle();
    chk("t2_tie1_grant_m0", 32'(grant_o), 32'd1);
    chk("t2_tie1_m0_ready", 32'(m0_ready), 32'd1);
    chk("t2_tie1_m1_ready", 32'(m1_ready), 32'd0);
    tick(); m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; settle();
    chk("t2_idle_gap1", 32'(grant_o), 32'd0);
    m0_valid = 1'b1; m1_valid = 1'b1;
    tick(); s_ready = 1'b1; s_rdata = 32'hB1; settle();
    chk("t2_tie2_grant_m1", 32'(grant_o), 32'd2);
    chk("t2_tie2_s_addr", s_addr, 32'h20);
    chk("t2_tie2_m1_ready", 32'(m1_ready), 32'd1);
    chk("t2_tie2_m1_rdata", m1_rdata, 32'hB1);
    chk("t2_tie2_m0_ready", 32'(m0_ready), 32'd0);
    tick(); m1_valid = 1'b0; s_ready = 1'b0; settle();
    chk("t2_idle_gap2", 32'(grant_o), 32'd0);
    chk("t2_idle_gap2_s_valid", 32'(s_valid), 32'd0);
    tick(); s_ready = 1'b1; s_rdata = 32'hC2; settle();
    chk("t2_m0_after_gap", 32'(grant_o), 32'd1);
    chk("t2_m0_after_gap_ready", 32'(m0_ready), 32'd1);
    tick(); m0_valid = 1'b0; s_ready = 1'b0; settle();

    // 3: M1 store; M0's idle fields carry junk that must not leak
    m0_addr = 32'hDEAD_0000; m0_wdata = 32'h5555_5555; m0_wstrb = 4'b1111;
    m1_valid = 1'b1; m1_addr = 32'h204; m1_wdata = 32'hAABB_CCDD; m1_wstrb = 4'b0011;
    tick(); settle();
    chk("t3_grant", 32'(grant_o), 32'd2);
    chk("t3_s_addr", s_addr, 32'h204);
    chk("t3_s_wdata", s_wdata, 32'hAABB_CCDD);
    chk("t3_s_wstrb", 32'(s_wstrb), 32'h3);
    s_ready = 1'b1; settle();
    chk("t3_m1_ready", 32'(m1_ready), 32'd1);
    chk("t3_m0_ready", 32'(m0_ready), 32'd0);
    tick(); m1_valid = 1'b0; s_ready = 1'b0; settle();

    // 4: reset mid GNT0 after priority last went to M0
    m0_valid = 1'b1; m0_addr = 32'h300; m0_wstrb = 4'b0000;
    tick(); s_ready = 1'b1; settle();
    chk("t4_pre_m0_ready", 32'(m0_ready), 32'd1);
    tick(); s_ready = 1'b0; settle();
    tick(); settle();
    chk("t4_gnt0", 32'(grant_o), 32'd1);
    s_ready = 1'b1; resetn = 1'b0; settle();
    chk("t4_rst_s_valid", 32'(s_valid), 32'd0);
    chk("t4_rst_grant", 32'(grant_o), 32'd0);
    chk("t4_rst_m0_ready", 32'(m0_ready), 32'd0);
    tick(); resetn = 1'b1; s_ready = 1'b0; m1_valid = 1'b1; m1_addr = 32'h400;
    tick(); settle();
    chk("t4_tie_after_reset_m0", 32'(grant_o), 32'd1);
    m0_valid = 1'b0; m1_valid = 1'b0;

    // 6: M0 withdraws during GNT0; memory answering late must not complete it
    tick(); tick(); m0_valid = 1'b1;
    tick(); settle();
    chk("t6_gnt0", 32'(s_valid), 32'd1);
    m0_valid = 1'b0; s_ready = 1'b1; settle();
    chk("t6_drop_s_valid", 32'(s_valid), 32'd0);
    chk("t6_drop_m0_ready", 32'(m0_ready), 32'd0);
    tick(); s_ready = 1'b0; settle();
    chk("t6_idle", 32'(grant_o), 32'd0);
    chk("t6_idle_m0_ready", 32'(m0_ready), 32'd0);

    // 5: memory never answers
    m0_valid = 1'b1; m0_addr = 32'h500;
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i <= 7; i++) begin
      tick(); settle();
      chk("t5_wait_s_valid", 32'(s_valid), 32'd1);
      chk("t5_wait_timeout", 32'(timeout_o), 32'd0);
    end
    tick(); settle();
    chk("t5_timeout", 32'(timeout_o), 32'd1);
    chk("t5_abort_ready", 32'(m0_ready), 32'd1);
    chk("t5_abort_rdata", m0_rdata, 32'hFFFF_FFFF);
    chk("t5_abort_s_valid", 32'(s_valid), 32'd0);
    tick(); m0_valid = 1'b0; settle();
    chk("t5_after_idle", 32'(grant_o), 32'd0);
    chk("t5_after_timeout", 32'(timeout_o), 32'd0);
`else
    for (int i = 1; i <= 120; i++) begin
      tick(); settle();
      chk("t5_hold_s_valid", 32'(s_valid), 32'd1);
      chk("t5_no_timeout", 32'(timeout_o), 32'd0);
    end
    chk("t5_no_ready", 32'(m0_ready), 32'd0);
    m0_valid = 1'b0;
    tick(); settle();
    chk("t5_release_idle", 32'(grant_o), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
